// File: rtl/ecdsa_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ecdsa_vector_sequencer
// Brief  : Streams ECDSA known-answer vectors from a synchronous ROM to a
//          verify engine, scores each verdict and keeps run tallies.
// Rev    : 1.0 - initial release
// ============================================================================
module ecdsa_vector_sequencer #(
    parameter int KEY_W   = 256,
    parameter int HASH_W  = 256,
    parameter int NUM_VEC = 64,
    parameter int IDX_W   = $clog2(NUM_VEC),
    parameter int CNT_W   = $clog2(NUM_VEC + 1),
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  vec_count,
    output logic              vec_rd_en,
    output logic [IDX_W-1:0]  vec_addr,
    input  logic [KEY_W-1:0]  vec_qx,
    input  logic [KEY_W-1:0]  vec_qy,
    input  logic [KEY_W-1:0]  vec_r,
    input  logic [KEY_W-1:0]  vec_s,
    input  logic [HASH_W-1:0] vec_hash,
    input  logic [1:0]        vec_expect,
    output logic              dut_valid,
    input  logic              dut_ready,
    output logic [KEY_W-1:0]  dut_qx,
    output logic [KEY_W-1:0]  dut_qy,
    output logic [KEY_W-1:0]  dut_r,
    output logic [KEY_W-1:0]  dut_s,
    output logic [HASH_W-1:0] dut_hash,
    input  logic              dut_res_valid,
    input  logic              dut_res_ok,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic [CNT_W-1:0]  tmo_cnt,
    output logic              first_fail_vld,
    output logic [IDX_W-1:0]  first_fail_idx
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] C_NUM_VEC     = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_ONE     = IDX_W'(1);
    localparam logic [TMO_W-1:0] C_TMO_ONE     = TMO_W'(1);
    localparam logic [TMO_W-1:0] C_TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0]       C_EXP_INVALID = 2'b00;
    localparam logic [1:0]       C_EXP_VALID   = 2'b01;
    localparam logic [1:0]       C_EXP_ACC     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic [TMO_W-1:0]   r_tmo;
    logic [KEY_W-1:0]   r_qx;
    logic [KEY_W-1:0]   r_qy;
    logic [KEY_W-1:0]   r_r;
    logic [KEY_W-1:0]   r_s;
    logic [HASH_W-1:0]  r_hash;
    logic [1:0]         r_expect;
    logic               r_res_ok;
    logic               r_timed_out;
    logic [CNT_W-1:0]   r_pass;
    logic [CNT_W-1:0]   r_fail;
    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic               r_ff_vld;
    logic [IDX_W-1:0]   r_ff_idx;

    logic [CNT_W-1:0]   w_count_clamped;
    logic               w_last;
    logic               w_tmo_hit;
    logic               w_match;
    logic               w_rd_en;
    logic               w_dut_valid;
    logic               w_busy;
    logic               w_done;

    assign w_count_clamped = (vec_count > C_NUM_VEC) ? C_NUM_VEC : vec_count;
    assign w_last          = ((CNT_W'(r_idx) + C_CNT_ONE) == r_count);
    assign w_tmo_hit       = (r_tmo == C_TMO_LAST);
    assign w_match         = ((r_expect == C_EXP_VALID)   &&  r_res_ok) ||
                             ((r_expect == C_EXP_INVALID) && !r_res_ok);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs; dut_valid depends on state only
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_dut_valid = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (vec_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_rd_en     = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_dut_valid = 1'b1;
                w_busy      = 1'b1;
                if (dut_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (dut_res_valid || w_tmo_hit) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_busy      = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: payload capture, timeout counter, scoring and tallies
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_count     <= '0;
            r_tmo       <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_r         <= '0;
            r_s         <= '0;
            r_hash      <= '0;
            r_expect    <= '0;
            r_res_ok    <= 1'b0;
            r_timed_out <= 1'b0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_acc       <= '0;
            r_tmo_cnt   <= '0;
            r_ff_vld    <= 1'b0;
            r_ff_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_count     <= w_count_clamped;
                        r_timed_out <= 1'b0;
                        r_pass      <= '0;
                        r_fail      <= '0;
                        r_acc       <= '0;
                        r_tmo_cnt   <= '0;
                        r_ff_vld    <= 1'b0;
                        r_ff_idx    <= '0;
                    end
                end
                S_LOAD: begin
                    r_qx     <= vec_qx;
                    r_qy     <= vec_qy;
                    r_r      <= vec_r;
                    r_s      <= vec_s;
                    r_hash   <= vec_hash;
                    r_expect <= vec_expect;
                end
                S_SEND: begin
                    if (dut_ready) begin
                        r_tmo       <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dut_res_valid) begin
                        r_res_ok <= dut_res_ok;
                    end else if (w_tmo_hit) begin
                        // Timeout is scored here so CHECK only advances the index
                        r_timed_out <= 1'b1;
                        r_tmo_cnt   <= r_tmo_cnt + C_CNT_ONE;
                        r_fail      <= r_fail + C_CNT_ONE;
                        if (!r_ff_vld) begin
                            r_ff_vld <= 1'b1;
                            r_ff_idx <= r_idx;
                        end
                    end else begin
                        r_tmo <= r_tmo + C_TMO_ONE;
                    end
                end
                S_CHECK: begin
                    if (!r_timed_out) begin
                        if (r_expect == C_EXP_ACC) begin
                            r_acc <= r_acc + C_CNT_ONE;
                        end else if (w_match) begin
                            r_pass <= r_pass + C_CNT_ONE;
                        end else begin
                            r_fail <= r_fail + C_CNT_ONE;
                            if (!r_ff_vld) begin
                                r_ff_vld <= 1'b1;
                                r_ff_idx <= r_idx;
                            end
                        end
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + C_IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vec_rd_en      = w_rd_en;
    assign vec_addr       = r_idx;
    assign dut_valid      = w_dut_valid;
    assign dut_qx         = r_qx;
    assign dut_qy         = r_qy;
    assign dut_r          = r_r;
    assign dut_s          = r_s;
    assign dut_hash       = r_hash;
    assign busy           = w_busy;
    assign done           = w_done;
    assign pass_cnt       = r_pass;
    assign fail_cnt       = r_fail;
    assign acc_cnt        = r_acc;
    assign tmo_cnt        = r_tmo_cnt;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;

endmodule
`default_nettype wire

// File: tb/tb_ecdsa_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ecdsa_vector_sequencer
// Brief  : Directed self-checking bench with a ROM model and a verify-engine
//          responder whose ready stall, latency and verdict are per vector.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ecdsa_vector_sequencer;

    localparam int KEY_W   = 521;
    localparam int HASH_W  = 512;
    localparam int NUM_VEC = 8;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = $clog2(NUM_VEC);
    localparam int CNT_W   = $clog2(NUM_VEC + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  vec_count;
    logic              vec_rd_en;
    logic [IDX_W-1:0]  vec_addr;
    logic [KEY_W-1:0]  vec_qx, vec_qy, vec_r, vec_s;
    logic [HASH_W-1:0] vec_hash;
    logic [1:0]        vec_expect;
    logic              dut_valid;
    logic              dut_ready;
    logic [KEY_W-1:0]  dut_qx, dut_qy, dut_r, dut_s;
    logic [HASH_W-1:0] dut_hash;
    logic              dut_res_valid;
    logic              dut_res_ok;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt, acc_cnt, tmo_cnt;
    logic              first_fail_vld;
    logic [IDX_W-1:0]  first_fail_idx;

    always #5 clk = ~clk;

    ecdsa_vector_sequencer #(
        .KEY_W   (KEY_W),
        .HASH_W  (HASH_W),
        .NUM_VEC (NUM_VEC),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .vec_count      (vec_count),
        .vec_rd_en      (vec_rd_en),
        .vec_addr       (vec_addr),
        .vec_qx         (vec_qx),
        .vec_qy         (vec_qy),
        .vec_r          (vec_r),
        .vec_s          (vec_s),
        .vec_hash       (vec_hash),
        .vec_expect     (vec_expect),
        .dut_valid      (dut_valid),
        .dut_ready      (dut_ready),
        .dut_qx         (dut_qx),
        .dut_qy         (dut_qy),
        .dut_r          (dut_r),
        .dut_s          (dut_s),
        .dut_hash       (dut_hash),
        .dut_res_valid  (dut_res_valid),
        .dut_res_ok     (dut_res_ok),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .acc_cnt        (acc_cnt),
        .tmo_cnt        (tmo_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
    );

    // Per-vector ROM expectation and responder behaviour
    logic [1:0] rom_exp [NUM_VEC];
    logic       rsp_ok  [NUM_VEC];
    logic       rsp_en  [NUM_VEC];
    int         rsp_lat [NUM_VEC];
    int         stall_left = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc     = 0;
    int hs_run  = 0;
    int hs_vec  = 0;
    bit hs_new  = 1'b0;
    int hs0_cyc = -1;
    int rd1_cyc = -1;

    // Field pattern: word 0 low byte carries the vector index
    function automatic logic [KEY_W-1:0] kpat(input int sel, input int a);
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = {8'hA5, 4'(i), 4'(sel), 8'h3C, 8'(a)};
        return t[KEY_W-1:0];
    endfunction

    function automatic logic [HASH_W-1:0] hpat(input int sel, input int a);
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = {8'hA5, 4'(i), 4'(sel), 8'h3C, 8'(a)};
        return t[HASH_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_tallies(input string tag, input int p, input int f, input int a,
                                 input int t, input int fv, input int fi);
        check({tag, "_pass"}, 64'(pass_cnt), 64'(p));
        check({tag, "_fail"}, 64'(fail_cnt), 64'(f));
        check({tag, "_acc"},  64'(acc_cnt),  64'(a));
        check({tag, "_tmo"},  64'(tmo_cnt),  64'(t));
        check({tag, "_ffvld"}, 64'(first_fail_vld), 64'(fv));
        if (fv != 0) check({tag, "_ffidx"}, 64'(first_fail_idx), 64'(fi));
    endtask

    task automatic load_cfg(input logic [15:0] exps, input logic [7:0] oks, input logic [7:0] ens);
        for (int i = 0; i < NUM_VEC; i++) begin
            rom_exp[i] = exps[2*i +: 2];
            rsp_ok[i]  = oks[i];
            rsp_en[i]  = ens[i];
            rsp_lat[i] = 0;
        end
    endtask

    // Starts a run and follows it to done; payload is checked on every valid cycle
    task automatic run(input string tag, input int count, input int n_vec, input int stall);
        int  ndone;
        int  valid_cyc;
        bit  busy_seen;
        bit  finished;
        logic ok;
        ndone = 0; valid_cyc = 0; busy_seen = 1'b0; finished = 1'b0;
        hs_run = 0;
        stall_left = stall;
        @(negedge clk);
        vec_count = CNT_W'(count);
        start = 1'b1;
        for (int c = 0; c < 2000 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (dut_valid) begin
                valid_cyc++;
                ok = (dut_qx == kpat(0, hs_run)) && (dut_qy == kpat(1, hs_run)) &&
                     (dut_r  == kpat(2, hs_run)) && (dut_s  == kpat(3, hs_run)) &&
                     (dut_hash == hpat(4, hs_run));
                check({tag, "_payload"}, 64'(ok), 64'd1);
            end
            if (done) begin
                ndone++;
                finished = 1'b1;
            end
        end
        check({tag, "_finished"}, 64'(finished), 64'd1);
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check({tag, "_done_pulses"}, 64'(ndone), 64'd1);
        check({tag, "_busy_seen"}, 64'(busy_seen), 64'(n_vec > 0));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_handshakes"}, 64'(hs_run), 64'(n_vec));
        check({tag, "_valid_cycles"}, 64'(valid_cyc), 64'(n_vec + stall));
    endtask

    // Handshake and ROM-read monitor
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (dut_valid && dut_ready) begin
                hs_vec = int'(dut_hash[7:0]);
                if (hs_run == 0) hs0_cyc = cyc;
                hs_run++;
                hs_new = 1'b1;
            end
            if (vec_rd_en && vec_addr == IDX_W'(1)) rd1_cyc = cyc;
        end
    end

    // ROM model: data presented only in the cycle after the read strobe
    initial begin : rom_model
        bit               pend;
        logic [IDX_W-1:0] a;
        pend = 1'b0;
        a    = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                vec_qx     = kpat(0, int'(a));
                vec_qy     = kpat(1, int'(a));
                vec_r      = kpat(2, int'(a));
                vec_s      = kpat(3, int'(a));
                vec_hash   = hpat(4, int'(a));
                vec_expect = rom_exp[a];
                pend       = 1'b0;
            end else begin
                vec_qx     = kpat(8, int'($urandom_range(0, 255)));
                vec_qy     = kpat(9, int'($urandom_range(0, 255)));
                vec_r      = kpat(10, int'($urandom_range(0, 255)));
                vec_s      = kpat(11, int'($urandom_range(0, 255)));
                vec_hash   = hpat(12, int'($urandom_range(0, 255)));
                vec_expect = 2'($urandom_range(0, 3));
            end
            if (vec_rd_en) begin
                pend = 1'b1;
                a    = vec_addr;
            end
        end
    end

    // Verify-engine responder
    initial begin : responder
        bit pend;
        int timer;
        int v;
        pend = 1'b0; timer = 0; v = 0;
        dut_ready = 1'b0; dut_res_valid = 1'b0; dut_res_ok = 1'b0;
        forever begin
            @(negedge clk);
            dut_res_valid = 1'b0;
            if (!rst_n) begin
                pend      = 1'b0;
                hs_new    = 1'b0;
                dut_ready = 1'b0;
            end else begin
                if (hs_new) begin
                    hs_new = 1'b0;
                    pend   = 1'b1;
                    v      = hs_vec;
                    timer  = rsp_lat[v];
                end
                if (pend) begin
                    if (timer == 0) begin
                        pend = 1'b0;
                        if (rsp_en[v]) begin
                            dut_res_valid = 1'b1;
                            dut_res_ok    = rsp_ok[v];
                        end
                    end else begin
                        timer--;
                    end
                end
                if (dut_valid && stall_left > 0) begin
                    stall_left--;
                    dut_ready = 1'b0;
                end else begin
                    dut_ready = dut_valid;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_count = '0;
        load_cfg(16'h0000, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);

        check("rst_busy",    64'(busy), 64'd0);
        check("rst_done",    64'(done), 64'd0);
        check("rst_valid",   64'(dut_valid), 64'd0);
        check("rst_rd_en",   64'(vec_rd_en), 64'd0);
        check("rst_payload", 64'((dut_qx == '0) && (dut_hash == '0)), 64'd1);
        check_tallies("rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Four vectors, verdict mirrors expectation
        load_cfg(16'h0011, 8'h05, 8'hFF);
        run("mirror", 4, 4, 0);
        check_tallies("mirror", 4, 0, 0, 0, 0, 0);

        // Mismatches at idx 2 and idx 4; first index must stick at 2
        load_cfg(16'h0051, 8'h19, 8'hFF);
        run("mismatch", 5, 5, 0);
        check_tallies("mismatch", 3, 2, 0, 0, 1, 2);

        // Ready held low for 10 cycles on vector 0
        load_cfg(16'h0005, 8'h03, 8'hFF);
        run("stall", 2, 2, 10);
        check_tallies("stall", 2, 0, 0, 0, 0, 0);

        // Vector 0 verdict arrives late, after the timeout fired
        load_cfg(16'h0005, 8'h03, 8'hFF);
        rsp_lat[0] = 17;
        hs0_cyc = -1;
        rd1_cyc = -1;
        run("timeout", 2, 2, 0);
        check_tallies("timeout", 1, 1, 0, 1, 1, 0);
        check("timeout_wait_len", 64'(rd1_cyc - hs0_cyc), 64'd18);

        // Acceptable verdicts and the reserved expectation code
        load_cfg(16'h003A, 8'h06, 8'hFF);
        run("acceptable", 3, 3, 0);
        check_tallies("acceptable", 0, 1, 2, 0, 1, 2);

        // Zero-length run clears tallies and still pulses done
        run("zero", 0, 0, 0);
        check_tallies("zero", 0, 0, 0, 0, 0, 0);

        // Count above ROM depth clamps to NUM_VEC
        load_cfg(16'h5555, 8'hFF, 8'hFF);
        run("clamp", 15, 8, 0);
        check_tallies("clamp", 8, 0, 0, 0, 0, 0);

        // Reset while waiting on vector 1, after vector 0 already failed
        load_cfg(16'h0005, 8'h02, 8'h01);
        hs_run = 0;
        @(negedge clk);
        vec_count = CNT_W'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && hs_run < 2; c++) @(negedge clk);
        check("rstw_reached_wait", 64'(hs_run), 64'd2);
        repeat (2) @(negedge clk);
        check("rstw_busy_before", 64'(busy), 64'd1);
        check("rstw_fail_before", 64'(fail_cnt), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw_busy",    64'(busy), 64'd0);
        check("rstw_valid",   64'(dut_valid), 64'd0);
        check("rstw_addr",    64'(vec_addr), 64'd0);
        check("rstw_payload", 64'((dut_qx == '0) && (dut_s == '0) && (dut_hash == '0)), 64'd1);
        check_tallies("rstw", 0, 0, 0, 0, 0, 0);

        load_cfg(16'h0005, 8'h03, 8'h03);
        run("after_rst", 2, 2, 0);
        check_tallies("after_rst", 2, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
